mem_arbiter: RTL and testbench

Two-port arbiter sharing the four-bank main memory between the instruction-cache controller (port 0) and the data-cache controller (port 1). It sits between both cache controllers and the banked memory. It chooses one requester per cycle and issues its read or write to memory only when the target bank is idle. It tracks in-flight reads so each read's returned data reaches the port that issued it.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a four-bank main memory.
// Port 0 is the instruction-cache controller, port 1 the data-cache controller.
// At most one request is issued per cycle, and only to an idle bank while the
// memory is not stalled. A MEM_LAT-deep shift register tracks in-flight reads,
// so each returned word is routed back to the port that issued the read.
// Build option: define ARB_FIXED_PRIO_EN to make port 1 win every tie.
// Without it, ties go round-robin on last_grant.
module mem_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_rd,
    input  logic          req0_wr,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ack,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    output logic          req0_err,

    input  logic          req1_rd,
    input  logic          req1_wr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ack,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic          req1_err,

    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic [3:0]    mem_busy,
    input  logic          mem_stall
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [MEM_LAT-1:0]   slot_vld_q, slot_vld_d;
    logic [MEM_LAT-1:0]   slot_own_q, slot_own_d;

    logic                 inflight0, inflight1;
    logic                 elig0, elig1;
    logic                 grant, winner, tie_winner;
    logic                 win_rd, win_wr, win_illegal;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_wdata;
    logic                 issue_rd;
    logic                 head_vld;

    // Per-port eligibility: a request, an idle target bank, no stall, and no read already outstanding.
    always_comb begin
        inflight0 = |(slot_vld_q & ~slot_own_q);
        inflight1 = |(slot_vld_q & slot_own_q);
        elig0 = rst && !mem_stall && (req0_rd || req0_wr)
                && !mem_busy[req0_addr[2:1]]
                && !(req0_rd && !req0_wr && inflight0);
        elig1 = rst && !mem_stall && (req1_rd || req1_wr)
                && !mem_busy[req1_addr[2:1]]
                && !(req1_rd && !req1_wr && inflight1);
    end

    // Winner selection: a lone eligible port wins; a tie goes to the configured priority.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        tie_winner = 1'b1;
`else
        tie_winner = ~last_grant_q;
`endif
        grant  = elig0 || elig1;
        winner = 1'b0;
        if (elig0 && elig1) begin
            winner = tie_winner;
        end else if (elig1) begin
            winner = 1'b1;
        end
        last_grant_d = grant ? winner : last_grant_q;
    end

    // Memory-side strobes and per-port ack/err. An illegal rd+wr request is acked but issues nothing.
    always_comb begin
        win_rd      = winner ? req1_rd    : req0_rd;
        win_wr      = winner ? req1_wr    : req0_wr;
        win_addr    = winner ? req1_addr  : req0_addr;
        win_wdata   = winner ? req1_wdata : req0_wdata;
        win_illegal = win_rd && win_wr;

        mem_rd    = grant && win_rd && !win_wr;
        mem_wr    = grant && win_wr && !win_rd;
        mem_addr  = grant ? win_addr  : '0;
        mem_wdata = grant ? win_wdata : '0;

        req0_ack  = grant && !winner;
        req1_ack  = grant && winner;
        req0_err  = req0_ack && win_illegal;
        req1_err  = req1_ack && win_illegal;
        issue_rd  = mem_rd;
    end

    // Return tracker shift and IDLE/BUSY next state. A new read enters the tail and the head retires.
    always_comb begin
        slot_vld_d = slot_vld_q >> 1;
        slot_own_d = slot_own_q >> 1;
        slot_vld_d[MEM_LAT-1] = issue_rd;
        slot_own_d[MEM_LAT-1] = issue_rd && winner;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_rd) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!(|slot_vld_d)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Route the returning word to the owner of the head entry. rdata is zero when not valid.
    always_comb begin
        head_vld    = rst && (state_q == ST_BUSY) && slot_vld_q[0];
        req0_rvalid = head_vld && !slot_own_q[0];
        req1_rvalid = head_vld && slot_own_q[0];
        req0_rdata  = req0_rvalid ? mem_rdata : '0;
        req1_rdata  = req1_rvalid ? mem_rdata : '0;
    end

    // State registers. Reset discards in-flight returns and gives the first tie to port 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            slot_vld_q   <= '0;
            slot_own_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            slot_vld_q   <= slot_vld_d;
            slot_own_q   <= slot_own_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Directed stimulus checks grants as they happen. Each expected read return is
// queued when its grant is expected, then popped and compared when an rvalid
// appears. A small memory model returns data MEM_LAT cycles after each mem_rd.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_rd, req0_wr, req0_ack, req0_rvalid, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_rd, req1_wr, req1_ack, req1_rvalid, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          mem_rd, mem_wr, mem_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_busy;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    logic exp_w;

    typedef struct packed { int due; logic [DW-1:0] data; } mret_t;
    typedef struct packed { int due; logic port; logic [DW-1:0] data; } exp_t;
    mret_t mq[$];
    exp_t  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    task automatic expect_rd(input logic port, input logic [AW-1:0] a);
        exp_q.push_back('{due: cyc + LAT, port: port, data: mem_data(a)});
    endtask

    task automatic idle_reqs();
        req0_rd = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
        req1_rd = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_reqs();
        mem_busy  = '0;
        mem_stall = 0;
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1;
    endtask

    // Memory model: capture each read strobe and return its data LAT cycles later.
    always @(negedge clk) begin
        if (mem_rd) mq.push_back('{due: cyc + LAT, data: mem_data(mem_addr)});
    end

    always @(posedge clk) begin
        mret_t m;
        cyc = cyc + 1;
        #1;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            mem_rdata = m.data;
        end else begin
            mem_rdata = '0;
        end
    end

    // Return monitor: every rvalid must match the oldest expected return.
    always @(negedge clk) begin
        exp_t e;
        if (req0_rvalid || req1_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {req1_rvalid, req0_rvalid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("rv_port", {req1_rvalid, req0_rvalid}, e.port ? 2'b10 : 2'b01);
                check("rv_data", e.port ? req1_rdata : req0_rdata, e.data);
                check("rv_cycle", cyc, e.due);
            end
        end
        if (!req0_rvalid) check("rdata0_zero", req0_rdata, 0);
        if (!req1_rvalid) check("rdata1_zero", req1_rdata, 0);
        if (!req0_ack && !req1_ack) begin
            check("idle_strobes", {mem_rd, mem_wr}, 0);
            check("idle_addr", mem_addr, 0);
            check("idle_wdata", mem_wdata, 0);
        end
    end

    initial begin
        rst = 0;
        idle_reqs();
        mem_busy = '0; mem_stall = 0; mem_rdata = '0;

        // Outputs must be zero under reset even with requests present.
        req0_rd = 1; req0_addr = 16'h0010; req1_wr = 1; req1_addr = 16'h0002;
        repeat (2) @(negedge clk);
        check("rst_ack", {req1_ack, req0_ack}, 0);
        check("rst_err", {req1_err, req0_err}, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rvalid", {req1_rvalid, req0_rvalid}, 0);
        @(posedge clk); #1;
        rst = 1;
        idle_reqs();

        // Single read from port 0, returns 0xBEEF two cycles later.
        req0_rd = 1; req0_addr = 16'h0010;
        @(negedge clk);
        check("t1_ack0", req0_ack, 1);
        check("t1_ack1", req1_ack, 0);
        check("t1_mem_rd", mem_rd, 1);
        check("t1_addr", mem_addr, 16'h0010);
        expect_rd(0, 16'h0010);
        @(posedge clk); #1;
        idle_reqs();
        repeat (4) begin
            @(negedge clk);
            check("t1_rv1_quiet", req1_rvalid, 0);
        end

        // Both ports write every cycle: round-robin alternates, fixed priority favours port 1.
        do_reset();
        req0_wr = 1; req0_addr = 16'h0000; req0_wdata = 16'h1111;
        req1_wr = 1; req1_addr = 16'h0002; req1_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = (i % 2 == 1);
`endif
            check("t2_ack0", req0_ack, !exp_w);
            check("t2_ack1", req1_ack, exp_w);
            check("t2_mem_wr", mem_wr, 1);
            check("t2_addr", mem_addr, exp_w ? 16'h0002 : 16'h0000);
            check("t2_wdata", mem_wdata, exp_w ? 16'h2222 : 16'h1111);
            @(posedge clk); #1;
        end

        // A busy bank blocks only its own requester.
        do_reset();
        mem_busy = 4'b0001;
        req0_rd = 1; req0_addr = 16'h0000;
        req1_wr = 1; req1_addr = 16'h0004; req1_wdata = 16'h3333;
        @(negedge clk);
        check("t3_ack0_busy", req0_ack, 0);
        check("t3_ack1", req1_ack, 1);
        check("t3_mem_wr", {mem_rd, mem_wr}, 2'b01);
        check("t3_addr", mem_addr, 16'h0004);
        @(posedge clk); #1;
        mem_busy = 4'b0000; req1_wr = 0;
        @(negedge clk);
        check("t3_ack0_free", req0_ack, 1);
        check("t3_mem_rd", mem_rd, 1);
        check("t3_addr2", mem_addr, 16'h0000);
        expect_rd(0, 16'h0000);
        // A stall holds off both ports for that cycle.
        @(posedge clk); #1;
        req0_rd = 0; req0_wr = 1; req0_addr = 16'h0008;
        req1_wr = 1; req1_addr = 16'h000A;
        mem_stall = 1;
        @(negedge clk);
        check("t3_stall_ack", {req1_ack, req0_ack}, 0);
        check("t3_stall_strobe", {mem_rd, mem_wr}, 0);
        @(posedge clk); #1;
        mem_stall = 0;
        @(negedge clk);
        check("t3_unstall_ack", {req1_ack, req0_ack}, 2'b10);
        @(posedge clk); #1;
        idle_reqs();
        repeat (3) @(negedge clk);

        // Illegal rd+wr: acked with err, no strobe, and still takes the round-robin turn.
        do_reset();
        req0_rd = 1; req0_wr = 1; req0_addr = 16'h0008;
        @(negedge clk);
        check("t4_ack0", req0_ack, 1);
        check("t4_err0", req0_err, 1);
        check("t4_strobes", {mem_rd, mem_wr}, 0);
        check("t4_err1", {req1_ack, req1_err}, 0);
        @(posedge clk); #1;
        req0_rd = 0; req0_wr = 1; req0_addr = 16'h0000;
        req1_wr = 1; req1_addr = 16'h0002;
        @(negedge clk);
        check("t4_next_tie", {req1_ack, req0_ack}, 2'b10);
        check("t4_err_clear", req0_err, 0);
        @(posedge clk); #1;
        idle_reqs();
        repeat (3) @(negedge clk);

        // A second read from port 0 waits until its first return has arrived.
        do_reset();
        req0_rd = 1; req0_addr = 16'h0020;
        @(negedge clk);
        check("t5_first_ack", req0_ack, 1);
        expect_rd(0, 16'h0020);
        @(posedge clk); #1;
        req0_addr = 16'h0030;
        req1_rd = 1; req1_addr = 16'h0006;
        @(negedge clk);
        check("t5_blk_ack0_a", req0_ack, 0);
        check("t5_p1_ack", req1_ack, 1);
        check("t5_p1_addr", mem_addr, 16'h0006);
        expect_rd(1, 16'h0006);
        @(posedge clk); #1;
        req1_rd = 0;
        @(negedge clk);
        check("t5_blk_ack0_b", req0_ack, 0);
        check("t5_first_rv", req0_rvalid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_second_ack", req0_ack, 1);
        check("t5_second_addr", mem_addr, 16'h0030);
        check("t5_p1_rv", req1_rvalid, 1);
        expect_rd(0, 16'h0030);
        @(posedge clk); #1;
        idle_reqs();
        repeat (4) @(negedge clk);

        // Reset one cycle after a read issue discards the return.
        do_reset();
        req0_rd = 1; req0_addr = 16'h0040;
        @(negedge clk);
        check("t6_ack0", req0_ack, 1);
        @(posedge clk); #1;
        req0_rd = 0;
        req1_wr = 1; req1_addr = 16'h0002;
        rst = 0;
        @(negedge clk);
        check("t6_rst_ack", {req1_ack, req0_ack}, 0);
        check("t6_rst_strobe", {mem_rd, mem_wr}, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_rv", {req1_rvalid, req0_rvalid}, 0);
        @(posedge clk); #1;
        rst = 1;
        req1_wr = 0;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_rv", {req1_rvalid, req0_rvalid}, 0);
        end

        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
